inst_cache: RTL and testbench

- Read-only, direct-mapped instruction cache that responds to the fetch unit's memory read interface (mem_read/mem_address in, mem_rdata/mem_resp out).
- On a miss it starts a 4-beat, 64-bit burst read from physical memory, installs the 32-byte line, then answers the fetch unit.
- Sits between the fetch unit and the memory arbiter / physical memory.

---
 rtl/inst_cache_if.sv | 32 +++
 rtl/inst_cache.sv | 130 +++++++++++++
 tb/tb_inst_cache.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_if.sv
// inst_cache_if: groups the fetch-side read port and the physical-memory
// burst port of the instruction cache.
//   mem_read     fetch request, held with mem_address until mem_resp
//   mem_address  byte address of the instruction
//   mem_rdata    instruction word, valid while mem_resp=1
//   mem_resp     one-cycle completion pulse
//   pmem_read    burst read request, held until the 4th beat
//   pmem_address line-aligned burst address
//   pmem_rdata   64-bit burst beat
//   pmem_resp    beat valid strobe
// slave  : the cache side
// master : the fetch unit / physical memory side (testbench)
interface inst_cache_if;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        pmem_read;
    logic [31:0] pmem_address;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  mem_read, mem_address, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_read, pmem_address
    );

    modport master (
        output mem_read, mem_address, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_read, pmem_address
    );
endinterface

// File: rtl/inst_cache.sv
// inst_cache: read-only direct-mapped instruction cache with 32-byte lines.
// A miss fetches the line as a 4-beat 64-bit burst, installs it, then
// re-checks the request, which now hits.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (clears valid bits, FSM, beat count)
//   bus  inst_cache_if.slave: fetch read port + physical-memory burst port
// Parameters:
//   S_INDEX  index bits (2**S_INDEX sets); TAG_W is derived.
module inst_cache #(
    parameter  int S_INDEX = 3,
    localparam int TAG_W   = 32 - 5 - S_INDEX
) (
    input  logic         clk,
    input  logic         rst,
    inst_cache_if.slave  bus
);
    localparam int SETS = 2 ** S_INDEX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t state, state_next;

    // Request register; the two byte-offset bits are never needed.
    logic [31:2]        req_addr;
    logic [S_INDEX-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         req_word;

    logic [SETS-1:0]    valid_bits;
    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [255:0]       data_mem [SETS];

    // Beats 0..2 are buffered; beat 3 is taken straight from the bus
    // when the whole line is written.
    logic [191:0]       line_buf;
    logic [1:0]         beat_cnt;

    logic               hit;
    logic               beat_take;
    logic               last_beat;
    logic [255:0]       line_sel;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^bus.mem_address[1:0];

    assign req_index = req_addr[4+S_INDEX:5];
    assign req_tag   = req_addr[31:5+S_INDEX];
    assign req_word  = req_addr[4:2];

    assign hit       = valid_bits[req_index] && (tag_mem[req_index] == req_tag);
    assign beat_take = (state == FILL) && bus.pmem_resp;
    assign last_beat = beat_take && (beat_cnt == 2'd3);
    assign line_sel  = data_mem[req_index];

    // Control state: FSM, valid bits, beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_bits <= '0;
            beat_cnt   <= 2'd0;
        end else begin
            state <= state_next;
            if (beat_take) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
            if (last_beat) begin
                valid_bits[req_index] <= 1'b1;
            end
        end
    end

    // Datapath storage: no reset, qualified by control state.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.mem_read) begin
            req_addr <= bus.mem_address[31:2];
        end
        if (beat_take) begin
            case (beat_cnt)
                2'd0:    line_buf[63:0]    <= bus.pmem_rdata;
                2'd1:    line_buf[127:64]  <= bus.pmem_rdata;
                2'd2:    line_buf[191:128] <= bus.pmem_rdata;
                default: ;
            endcase
        end
        if (last_beat) begin
            data_mem[req_index] <= {bus.pmem_rdata, line_buf};
            tag_mem[req_index]  <= req_tag;
        end
    end

    always_comb begin
        state_next       = state;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = 32'd0;
        bus.pmem_read    = 1'b0;
        bus.pmem_address = 32'd0;
        case (state)
            IDLE: begin
                if (bus.mem_read) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (hit) begin
                    // A request dropped while filling gets no response.
                    if (bus.mem_read) begin
                        bus.mem_resp  = 1'b1;
                        bus.mem_rdata = line_sel[{req_word, 5'b0} +: 32];
                    end
                    state_next = IDLE;
                end else begin
                    state_next = FILL;
                end
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {req_tag, req_index, 5'b0};
                if (last_beat) begin
                    state_next = CHECK;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed self-checking bench for inst_cache.
// Inputs are driven and outputs sampled on the falling clock edge.
// Line 0x60 carries words 0x11111111*w; every other line L carries
// words {L[15:0], w} so each word is unique and easy to hand-check.
module tb_inst_cache;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    inst_cache_if bus ();

    inst_cache #(.S_INDEX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] word_of(input logic [31:0] line, input int w);
        if (line == 32'h60) return 32'h1111_1111 * w;
        return {line[15:0], 16'(w)};
    endfunction

    function automatic logic [63:0] beat_of(input logic [31:0] line, input int k);
        return {word_of(line, 2 * k + 1), word_of(line, 2 * k)};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_beats(input logic [31:0] line, input int first, input int last, input int ws);
        for (int k = first; k <= last; k++) begin
            repeat (ws) begin
                bus.pmem_resp = 1'b0;
                tick();
            end
            bus.pmem_rdata = beat_of(line, k);
            bus.pmem_resp  = 1'b1;
            tick();
            bus.pmem_resp  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_address = 32'd0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = 64'd0;
        tick();
        tick();
        checks++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL reset_mem_resp got %h want 0", bus.mem_resp); end
        checks++; if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL reset_pmem_read got %h want 0", bus.pmem_read); end
        checks++; if (bus.pmem_address !== 32'd0) begin failures++; $display("FAIL reset_pmem_address got %h want 0", bus.pmem_address); end
        checks++; if (bus.mem_rdata !== 32'd0) begin failures++; $display("FAIL reset_mem_rdata got %h want 0", bus.mem_rdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss();
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h68;
        tick();
        checks++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL cold_check_resp got %h want 0", bus.mem_resp); end
        tick();
        checks++; if (bus.pmem_read !== 1'b1) begin failures++; $display("FAIL cold_pmem_read got %h want 1", bus.pmem_read); end
        checks++; if (bus.pmem_address !== 32'h60) begin failures++; $display("FAIL cold_pmem_address got %h want 00000060", bus.pmem_address); end
        send_beats(32'h60, 0, 3, 0);
        checks++; if (bus.mem_resp !== 1'b1) begin failures++; $display("FAIL cold_resp got %h want 1", bus.mem_resp); end
        checks++; if (bus.mem_rdata !== 32'h2222_2222) begin failures++; $display("FAIL cold_rdata got %h want 22222222", bus.mem_rdata); end
        checks++; if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL cold_pmem_drop got %h want 0", bus.pmem_read); end
        bus.mem_read = 1'b0;
        tick();
        checks++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL cold_resp_pulse got %h want 0", bus.mem_resp); end
    endtask

    task automatic test_hit();
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h6C;
        tick();
        checks++; if (bus.mem_resp !== 1'b1) begin failures++; $display("FAIL hit6c_resp got %h want 1", bus.mem_resp); end
        checks++; if (bus.mem_rdata !== 32'h3333_3333) begin failures++; $display("FAIL hit6c_rdata got %h want 33333333", bus.mem_rdata); end
        checks++; if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL hit6c_pmem_read got %h want 0", bus.pmem_read); end
        bus.mem_read = 1'b0;
        tick();
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h7C;
        tick();
        checks++; if (bus.mem_resp !== 1'b1) begin failures++; $display("FAIL hit7c_resp got %h want 1", bus.mem_resp); end
        checks++; if (bus.mem_rdata !== 32'h7777_7777) begin failures++; $display("FAIL hit7c_rdata got %h want 77777777", bus.mem_rdata); end
        checks++; if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL hit7c_pmem_read got %h want 0", bus.pmem_read); end
        bus.mem_read = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h160;
        tick();
        checks++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL conf160_check_resp got %h want 0", bus.mem_resp); end
        tick();
        checks++; if (bus.pmem_address !== 32'h160) begin failures++; $display("FAIL conf160_pmem_address got %h want 00000160", bus.pmem_address); end
        send_beats(32'h160, 0, 3, 0);
        checks++; if (bus.mem_rdata !== 32'h0160_0000 || bus.mem_resp !== 1'b1) begin failures++; $display("FAIL conf160_rdata got %h/%h want 01600000/1", bus.mem_rdata, bus.mem_resp); end
        bus.mem_read = 1'b0;
        tick();
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h64;
        tick();
        checks++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL conf60_check_resp got %h want 0", bus.mem_resp); end
        tick();
        checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h60) begin failures++; $display("FAIL conf60_pmem got %h/%h want 1/00000060", bus.pmem_read, bus.pmem_address); end
        send_beats(32'h60, 0, 3, 0);
        checks++; if (bus.mem_rdata !== 32'h1111_1111 || bus.mem_resp !== 1'b1) begin failures++; $display("FAIL conf60_rdata got %h/%h want 11111111/1", bus.mem_rdata, bus.mem_resp); end
        bus.mem_read = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        int bad_addr = 0;
        int bad_resp = 0;
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h1A4;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            repeat (3) begin
                bus.pmem_resp = 1'b0;
                bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                tick();
                if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h1A0) bad_addr++;
                if (bus.mem_resp !== 1'b0) bad_resp++;
            end
            bus.pmem_rdata = beat_of(32'h1A0, k);
            bus.pmem_resp = 1'b1;
            tick();
            bus.pmem_resp = 1'b0;
        end
        checks++; if (bad_addr != 0) begin failures++; $display("FAIL ws_pmem_stable got %0d bad cycles want 0", bad_addr); end
        checks++; if (bad_resp != 0) begin failures++; $display("FAIL ws_early_resp got %0d bad cycles want 0", bad_resp); end
        checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h01A0_0001) begin failures++; $display("FAIL ws_rdata got %h/%h want 01a00001/1", bus.mem_rdata, bus.mem_resp); end
        bus.mem_read = 1'b0;
        tick();
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h1BC;
        tick();
        checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h01A0_0007) begin failures++; $display("FAIL ws_word7 got %h/%h want 01a00007/1", bus.mem_rdata, bus.mem_resp); end
        bus.mem_read = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        // Stray beats outside a fill must be ignored.
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h1A4;
        tick();
        checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h01A0_0001) begin failures++; $display("FAIL b2b_first got %h/%h want 01a00001/1", bus.mem_rdata, bus.mem_resp); end
        bus.mem_address = 32'h1A8;
        tick();
        checks++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL b2b_idle_resp got %h want 0", bus.mem_resp); end
        tick();
        checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h01A0_0002) begin failures++; $display("FAIL b2b_second got %h/%h want 01a00002/1", bus.mem_rdata, bus.mem_resp); end
        bus.mem_read = 1'b0;
        bus.pmem_resp = 1'b0;
        tick();
    endtask

    task automatic test_abandon();
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h304;
        tick();
        tick();
        checks++; if (bus.pmem_address !== 32'h300) begin failures++; $display("FAIL ab_pmem_address got %h want 00000300", bus.pmem_address); end
        send_beats(32'h300, 0, 1, 0);
        bus.mem_read = 1'b0;
        send_beats(32'h300, 2, 3, 0);
        checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin failures++; $display("FAIL ab_no_resp got %h/%h want 0/0", bus.mem_resp, bus.pmem_read); end
        tick();
        checks++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL ab_after got %h want 0", bus.mem_resp); end
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h30C;
        tick();
        checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h0300_0003) begin failures++; $display("FAIL ab_rehit got %h/%h want 03000003/1", bus.mem_rdata, bus.mem_resp); end
        bus.mem_read = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_fill();
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h2C8;
        tick();
        tick();
        send_beats(32'h2C0, 0, 1, 0);
        rst = 1'b1;
        bus.mem_read = 1'b0;
        tick();
        checks++; if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin failures++; $display("FAIL rmf_outputs got %h/%h want 0/0", bus.pmem_read, bus.mem_resp); end
        checks++; if (bus.pmem_address !== 32'd0) begin failures++; $display("FAIL rmf_pmem_address got %h want 0", bus.pmem_address); end
        rst = 1'b0;
        tick();
        bus.mem_read = 1'b1;
        tick();
        checks++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL rmf_remiss got %h want 0", bus.mem_resp); end
        tick();
        checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h2C0) begin failures++; $display("FAIL rmf_refetch got %h/%h want 1/000002c0", bus.pmem_read, bus.pmem_address); end
        send_beats(32'h2C0, 0, 3, 1);
        checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h02C0_0002) begin failures++; $display("FAIL rmf_rdata got %h/%h want 02c00002/1", bus.mem_rdata, bus.mem_resp); end
        bus.mem_read = 1'b0;
        tick();
        // Reset invalidated every set, so an older line misses too.
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h1A4;
        tick();
        checks++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL rmf_all_invalid got %h want 0", bus.mem_resp); end
        tick();
        send_beats(32'h1A0, 0, 3, 0);
        bus.mem_read = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_address = 32'd0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = 64'd0;
        tick();
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_wait_states();
        test_back_to_back();
        test_abandon();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
